reg_wb_arbiter: RTL

//  Write-back stage feeding the register file write port (rg_wrt_en/addr/data).

---
 rtl/reg_wb_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: write-back arbiter that merges an ALU result stream with a buffered load/mul stream.
//
// Ports:
//   clk                      rising-edge clock
//   reset                    asynchronous, active-low reset
//   alu_valid/ready/rd/data  single-cycle ALU result handshake (ready drops only on a forced FIFO pop)
//   mem_valid/ready/rd/data  long-latency result handshake into the FIFO (ready = !full)
//   rg_wrt_en/addr/data      registered register-file write port (x0 writes suppressed)
//   pend_mask                destinations still waiting in the FIFO (bit 0 always 0)
//   fifo_count               current FIFO occupancy
//
// Build option: define WB_MEM_BYPASS_EN to let a mem result skip the empty FIFO
// when the ALU is idle, landing on the write port one cycle after acceptance.
module reg_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [4:0]                 alu_rd,
    input  logic [31:0]                alu_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [4:0]                 mem_rd,
    input  logic [31:0]                mem_data,
    output logic                       rg_wrt_en,
    output logic [4:0]                 rg_wrt_addr,
    output logic [31:0]                rg_wrt_data,
    output logic [31:0]                pend_mask,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]    rd_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          wen_q, wen_d;
    logic [4:0]    addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          empty, full, force_pop, take_alu, pop, push, byp, sel;
    logic [4:0]    sel_rd;
    logic [31:0]   sel_data;
    logic [AW-1:0] off;

    assign empty     = count_q == '0;
    assign full      = count_q == CW'(DEPTH);
    // A FIFO that has lost STARVE_MAX times in a row wins regardless of the ALU.
    assign force_pop = (starve_q == SW'(STARVE_MAX)) && !empty;
    assign take_alu  = alu_valid && !force_pop;
    assign pop       = force_pop || (!alu_valid && !empty);
`ifdef WB_MEM_BYPASS_EN
    assign byp       = mem_valid && empty && !alu_valid;
`else
    assign byp       = 1'b0;
`endif
    assign push      = mem_valid && !full && !byp;
    assign sel       = take_alu || pop || byp;
    assign sel_rd    = take_alu ? alu_rd : pop ? rd_q[rptr_q] : mem_rd;
    assign sel_data  = take_alu ? alu_data : pop ? data_q[rptr_q] : mem_data;

    assign alu_ready   = !force_pop;
    assign mem_ready   = !full;
    assign fifo_count  = count_q;
    assign rg_wrt_en   = wen_q;
    assign rg_wrt_addr = addr_q;
    assign rg_wrt_data = wdata_q;

    always_comb begin
        wptr_d   = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d   = pop ? rptr_q + 1'b1 : rptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        starve_d = (pop || empty) ? '0 : (take_alu && starve_q != SW'(STARVE_MAX)) ? starve_q + 1'b1 : starve_q;
        wen_d    = sel && sel_rd != 5'd0;
        addr_d   = sel ? sel_rd : addr_q;
        wdata_d  = sel ? sel_data : wdata_q;
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        pend_mask = '0;
        off       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - rptr_q;
            if ({1'b0, off} < count_q)
                pend_mask[rd_q[i]] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wptr_q]   <= mem_rd;
            data_q[wptr_q] <= mem_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end
endmodule
